// File: rtl/prng_stream_checker_pkg.sv
// Shared PRNG recurrence constants and checker state encoding.
// Used by the generator and by prng_stream_checker.
package prng_chk_pkg;

  localparam int unsigned PRNG_W    = 12;
  localparam int unsigned PRNG_MULT = 3;
  localparam int unsigned PRNG_INC  = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/prng_stream_checker_if.sv
// Sample/control bus between the generator/test logic and prng_stream_checker.
// The master drives control and samples; the slave returns status and statistics.
interface prng_stream_checker_if #(
  parameter int unsigned W     = 12,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             locked;
  logic             mismatch;
  logic [W-1:0]     expected;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] err_count;
  logic             sync_lost;

  modport master (
    output start, stop, in_valid, in_data,
    input  locked, mismatch, expected, match_count, err_count, sync_lost
  );

  modport slave (
    input  start, stop, in_valid, in_data,
    output locked, mismatch, expected, match_count, err_count, sync_lost
  );
endinterface

// File: rtl/prng_stream_checker_step.sv
// One step of the PRNG recurrence f(x) = (MULT*x + INC) mod 2^W, purely combinational.
// The product is formed at W+2 bits and then truncated.
module prng_step
  import prng_chk_pkg::*;
#(
  parameter int unsigned W    = PRNG_W,
  parameter int unsigned MULT = PRNG_MULT,
  parameter int unsigned INC  = PRNG_INC
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] fx_c_o
);
  localparam int unsigned WX = W + 2;

  logic [WX-1:0] wide_c;

  assign wide_c = WX'(MULT) * WX'(x_i) + WX'(INC);
  assign fx_c_o = wide_c[W-1:0];
endmodule

// File: rtl/prng_stream_checker.sv
// Receive-side PRNG stream checker: acquires lock on the recurrence, then flywheels and flags deviations.
// Optional macro PRNG_CHK_ERR_CNT_EN builds the err_count statistic; otherwise err_count is tied to 0.
module prng_stream_checker
  import prng_chk_pkg::*;
#(
  parameter int unsigned W           = PRNG_W,
  parameter int unsigned MULT        = PRNG_MULT,
  parameter int unsigned INC         = PRNG_INC,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  prng_stream_checker_if.slave bus
);
  localparam int unsigned MISS_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);

  state_e             state_q, state_d;
  logic [W-1:0]       exp_q, exp_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               mismatch_q, mismatch_d;
  logic               sync_lost_q, sync_lost_d;
  logic [W-1:0]       f_in_c, f_exp_c;
  logic [MISS_W-1:0]  miss_inc_c;
`ifdef PRNG_CHK_ERR_CNT_EN
  logic [CNT_W-1:0]   err_q, err_d;
`endif

  prng_step #(.W(W), .MULT(MULT), .INC(INC)) u_step_in  (.x_i(bus.in_data), .fx_c_o(f_in_c));
  prng_step #(.W(W), .MULT(MULT), .INC(INC)) u_step_exp (.x_i(exp_q),       .fx_c_o(f_exp_c));

  assign miss_inc_c = miss_q + MISS_W'(1);

  // Next-state, prediction and statistics; stop dominates every other input.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_d     = match_q;
    miss_d      = miss_q;
    mismatch_d  = 1'b0;
    sync_lost_d = 1'b0;
`ifdef PRNG_CHK_ERR_CNT_EN
    err_d       = err_q;
`endif
    if (state_q != S_IDLE && bus.stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            match_d = '0;
            miss_d  = '0;
`ifdef PRNG_CHK_ERR_CNT_EN
            err_d   = '0;
`endif
            state_d = S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (bus.in_valid) begin
            exp_d   = f_in_c;
            state_d = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (bus.in_valid) begin
            if (bus.in_data == exp_q) begin
              exp_d   = f_exp_c;
              if (match_q != '1) match_d = match_q + CNT_W'(1);
              state_d = S_LOCKED;
            end else begin
              exp_d = f_in_c;
            end
          end
        end
        S_LOCKED: begin
          if (bus.in_valid) begin
            exp_d = f_exp_c;
            if (bus.in_data == exp_q) begin
              if (match_q != '1) match_d = match_q + CNT_W'(1);
              miss_d = '0;
            end else begin
              mismatch_d = 1'b1;
`ifdef PRNG_CHK_ERR_CNT_EN
              if (err_q != '1) err_d = err_q + CNT_W'(1);
`endif
              if (miss_inc_c == MISS_W'(LOSS_THRESH)) begin
                sync_lost_d = 1'b1;
                miss_d      = '0;
                state_d     = S_ACQUIRE;
              end else begin
                miss_d = miss_inc_c;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      sync_lost_q <= sync_lost_d;
    end
  end

`ifdef PRNG_CHK_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end
  assign bus.err_count = err_q;
`else
  assign bus.err_count = '0;
`endif

  assign bus.locked      = locked_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.sync_lost   = sync_lost_q;
  assign bus.expected    = exp_q;
  assign bus.match_count = match_q;
endmodule

// File: tb/tb_prng_stream_checker.sv
// Scoreboard bench for prng_stream_checker: directed vectors push expected responses,
// a monitor compares each registered response one cycle later.
module tb_prng_stream_checker;
  import prng_chk_pkg::*;

  typedef struct packed {
    logic        locked;
    logic        mismatch;
    logic        sync_lost;
    logic [11:0] expected;
    logic [15:0] match_count;
    logic [15:0] err_count;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  resp_t sb[$];
  resp_t mon_exp, mon_act;

  always #5 clk = ~clk;

  prng_stream_checker_if #(.W(12), .CNT_W(16)) bus ();

  prng_stream_checker #(
    .W(12), .MULT(3), .INC(4), .LOSS_THRESH(4), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int ec(input int x);
`ifdef PRNG_CHK_ERR_CNT_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue the response due after the next rising edge.
  task automatic s(input logic r, input logic st, input logic sp, input logic v, input logic [11:0] d,
                   input logic el, input logic em, input logic esl, input logic [11:0] ee,
                   input int mc, input int erc);
    resp_t e;
    @(negedge clk);
    rst          = r;
    bus.start    = st;
    bus.stop     = sp;
    bus.in_valid = v;
    bus.in_data  = d;
    e.locked      = el;
    e.mismatch    = em;
    e.sync_lost   = esl;
    e.expected    = ee;
    e.match_count = 16'(mc);
    e.err_count   = 16'(ec(erc));
    sb.push_back(e);
  endtask

  // Monitor: each rising edge presents a new registered response.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_exp = sb.pop_front();
      mon_act.locked      = bus.locked;
      mon_act.mismatch    = bus.mismatch;
      mon_act.sync_lost   = bus.sync_lost;
      mon_act.expected    = bus.expected;
      mon_act.match_count = bus.match_count;
      mon_act.err_count   = bus.err_count;
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL resp#%0d: got lk=%b mm=%b sl=%b exp=%03h mc=%0d ec=%0d, want lk=%b mm=%b sl=%b exp=%03h mc=%0d ec=%0d",
                 n_tests, mon_act.locked, mon_act.mismatch, mon_act.sync_lost, mon_act.expected,
                 mon_act.match_count, mon_act.err_count, mon_exp.locked, mon_exp.mismatch,
                 mon_exp.sync_lost, mon_exp.expected, mon_exp.match_count, mon_exp.err_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    //  r  st sp v  data     lk mm sl exp     mc ec
    s(1, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0);
    s(0, 0, 0, 1, 12'h123, 0, 0, 0, 12'h000, 0, 0);
    // Lock and match: 0x001 arrives with start and is ignored.
    s(0, 1, 0, 1, 12'h001, 0, 0, 0, 12'h000, 0, 0);
    s(0, 0, 0, 1, 12'h007, 0, 0, 0, 12'h019, 0, 0);
    s(0, 0, 0, 1, 12'h019, 1, 0, 0, 12'h04F, 1, 0);
    s(0, 0, 0, 0, 12'h000, 1, 0, 0, 12'h04F, 1, 0);
    s(0, 0, 0, 1, 12'h04F, 1, 0, 0, 12'h0F1, 2, 0);
    s(0, 0, 0, 1, 12'h0F1, 1, 0, 0, 12'h2D7, 3, 0);
    // Single error, then a match holds lock.
    s(0, 0, 0, 1, 12'h055, 1, 1, 0, 12'h889, 3, 1);
    s(0, 0, 0, 1, 12'h889, 1, 0, 0, 12'h99F, 4, 1);
    // Loss of sync after four consecutive misses.
    s(0, 0, 0, 1, 12'h000, 1, 1, 0, 12'hCE1, 4, 2);
    s(0, 0, 0, 1, 12'h000, 1, 1, 0, 12'h6A7, 4, 3);
    s(0, 0, 0, 1, 12'h000, 1, 1, 0, 12'h3F9, 4, 4);
    s(0, 0, 0, 1, 12'h000, 0, 1, 1, 12'hBEF, 4, 5);
    // Re-acquire, re-seed in CONFIRM, then lock across the wrap at 0xFFF.
    s(0, 0, 0, 1, 12'hAA9, 0, 0, 0, 12'hFFF, 4, 5);
    s(0, 0, 0, 1, 12'h123, 0, 0, 0, 12'h36D, 4, 5);
    s(0, 0, 0, 1, 12'hAA9, 0, 0, 0, 12'hFFF, 4, 5);
    s(0, 0, 0, 1, 12'hFFF, 1, 0, 0, 12'h001, 5, 5);
    s(0, 0, 0, 1, 12'h001, 1, 0, 0, 12'h007, 6, 5);
    // Stop beats a mismatching sample; IDLE holds everything.
    s(0, 0, 1, 1, 12'h555, 0, 0, 0, 12'h007, 6, 5);
    s(0, 0, 0, 1, 12'h007, 0, 0, 0, 12'h007, 6, 5);
    s(0, 1, 1, 0, 12'h000, 0, 0, 0, 12'h007, 6, 5);
    s(0, 1, 0, 0, 12'h000, 0, 0, 0, 12'h007, 0, 0);
    s(0, 0, 0, 1, 12'h007, 0, 0, 0, 12'h019, 0, 0);
    s(0, 0, 0, 1, 12'h019, 1, 0, 0, 12'h04F, 1, 0);
    // start while locked is ignored.
    s(0, 1, 0, 1, 12'h04F, 1, 0, 0, 12'h0F1, 2, 0);
    s(0, 0, 0, 1, 12'h000, 1, 1, 0, 12'h2D7, 2, 1);
    // Reset mid-stream overrides all inputs.
    s(1, 1, 0, 1, 12'h2D7, 0, 0, 0, 12'h000, 0, 0);
    s(0, 0, 0, 1, 12'h001, 0, 0, 0, 12'h000, 0, 0);
    s(0, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses still pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prng_stream_checker.md
# prng_stream_checker

Receive-side checker for the pseudorandom number stream driven by the generator FSM. It accepts sampled generator outputs, acquires lock on the recurrence x[n+1] = (3·x[n] + 4) mod 2^W, then free-runs its own prediction to flag every deviating sample. It sits on the generator's output bus and gives pass/fail and statistics to the test/debug logic.

## Interface
- W, 12, sample width; matches the generator's seed/prev width
- MULT, 3, recurrence multiplier
- INC, 4, recurrence increment
- LOSS_THRESH, 4, consecutive mismatches in LOCKED that drop lock (≥1)
- CNT_W, 16, statistics counter width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  arm checker (honoured only in IDLE)
- stop  in  1  disarm; return to IDLE
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  W  sampled generator output
- locked  out  1  high while in LOCKED
- mismatch  out  1  one-cycle pulse per mismatching sample in LOCKED
- expected  out  W  current prediction for the next sample
- match_count  out  CNT_W  matched samples since arm
- err_count  out  CNT_W  mismatched samples since arm
- sync_lost  out  1  one-cycle pulse when lock drops

## Operation
- f(x) = (MULT·x + INC) truncated to W bits; the intermediate is computed at W+2 bits before truncation.
- States: IDLE, ACQUIRE, CONFIRM, LOCKED.
- IDLE: input ignored. On start: clear both counters and the miss run, then go to ACQUIRE.
- ACQUIRE: on in_valid: expected ← f(in_data), then go to CONFIRM.
- CONFIRM: on in_valid:
  - If in_data == expected: expected ← f(expected), count the sample as a match, then go to LOCKED.
  - Otherwise: expected ← f(in_data) and stay in CONFIRM (re-seed from the stream).
- LOCKED: on in_valid, expected ← f(expected) in every case. The checker flywheels and never re-seeds from data.
  - Match: match_count++ and the miss run clears.
  - Mismatch: pulse mismatch, err_count++, miss run++.
  - When the miss run reaches LOSS_THRESH: pulse sync_lost, clear the miss run, go to ACQUIRE. Counters keep their values.
- stop in any non-IDLE state returns to IDLE.
  - stop beats start, in_valid and sync_lost in the same cycle; the sample is discarded and not counted.
  - Counters and expected hold in IDLE.
- start outside IDLE is ignored. start and stop together in IDLE: stay IDLE.
- Counters saturate at all-ones and do not wrap.
- No in_valid means no state change in any state. Gaps between samples are legal.

## Timing
- All outputs are registered.
- Reset values: state IDLE; locked 0, mismatch 0, sync_lost 0, expected 0, match_count 0, err_count 0, miss run 0.
- Latency is one cycle. A sample presented at edge N drives its mismatch, counters, expected and state at edge N+1.
- locked rises the cycle after the confirming sample. It falls in the same cycle as sync_lost, or the cycle after stop.
- Back-to-back in_valid at full clock rate is sustained with no stall. There is no back-pressure output.
- rst mid-operation returns every output to its reset value on the next edge and overrides all inputs.

## Configuration
- PRNG_CHK_ERR_CNT_EN:
  - Defined: err_count is implemented as described above.
  - Undefined: the err_count register is not built and err_count is tied to 0. mismatch, the miss run and sync_lost behave the same either way.

## Structure
- Package prng_chk_pkg holds:
  - the state enum (IDLE, ACQUIRE, CONFIRM, LOCKED)
  - the default constants for W, MULT and INC, so the generator and checker share one recurrence definition
- Sub-module prng_step is purely combinational, computes f(x), is parameterised by W/MULT/INC, and is reused by the generator.
- The top level holds the FSM, expected register, miss-run counter and statistics counters.

## Test plan
- Lock and match: rst, start, then samples 0x001, 0x007, 0x019, 0x04F, 0x0F1 → locked rises the cycle after 0x019; match_count = 3; err_count = 0; no mismatch pulses.
- Wrap-around: locked with expected = 0xFFF; send 0xFFF then 0x001 → both match; expected becomes 0x007.
- Single error: locked; send 0x055 where 0x04F is expected → one mismatch pulse; err_count = 1; expected = 0x0F1; next sample 0x0F1 matches; lock is held.
- Loss of sync with LOSS_THRESH = 4: send 4 consecutive wrong samples → sync_lost pulses on the 4th; locked falls; state is ACQUIRE; re-lock follows on a valid pair.
- Priority: in_valid with a mismatching sample, together with stop, while locked → no mismatch pulse, counters unchanged, IDLE next cycle. start while locked → ignored.
- Reset mid-stream and macro off: rst during LOCKED → all outputs 0 next edge. Build without PRNG_CHK_ERR_CNT_EN and inject errors → err_count stays 0 while mismatch still pulses.
